// File: rtl/mvm_uart_sequencer.sv
// mvm_uart_sequencer
// Byte-level protocol controller between the UART RX/TX pair and the MVM core.
// RX commands: 'K' followed by R*C bytes loads the weight matrix (row-major),
// 'X' followed by C bytes loads the input vector and launches one MVM. When the
// core reports done, the R result bytes are streamed out on the TX side,
// element 0 first.
//
// Handshake rule (both the s_ and m_ sides): a byte moves on a rising clk edge
// where valid and ready are both high. A producer holds its data stable and
// keeps valid high until that edge. ready may be low at any time. While a
// result is being sent, s_ready stays low, so RX bytes wait upstream and are
// never dropped.

module mvm_uart_sequencer #(
   parameter int R              = 2,
   parameter int C              = 2,
   parameter int W_K            = 4,
   parameter int W_X            = 4,
   parameter int W_Y_OUT        = 8,
   parameter int BITS_PER_WORD  = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [BITS_PER_WORD-1:0]   s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   output logic [BITS_PER_WORD-1:0]   m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [R*C*W_K-1:0]         mvm_k,
   output logic [C*W_X-1:0]           mvm_x,
   output logic                       mvm_start,
   input  logic                       mvm_done,
   input  logic [R*W_Y_OUT-1:0]       mvm_y,
   output logic                       busy,
   output logic                       err
);

   // Counter widths: the element counter spans the larger of the two loads
   // (R*C >= C always), the output counter spans R, the gap counter must be
   // able to hold TIMEOUT_CYCLES-1.
   localparam int NK = R * C;
   localparam int EW = $clog2(NK + 1);
   localparam int OW = $clog2(R + 1);
   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [EW-1:0] K_LAST   = EW'(NK - 1);
   localparam logic [EW-1:0] X_LAST   = EW'(C - 1);
   localparam logic [OW-1:0] OUT_LAST = OW'(R - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);

   // ASCII command bytes
   localparam logic [BITS_PER_WORD-1:0] CMD_K = BITS_PER_WORD'(8'h4B);
   localparam logic [BITS_PER_WORD-1:0] CMD_X = BITS_PER_WORD'(8'h58);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_K = 3'd1,
      ST_LOAD_X = 3'd2,
      ST_START  = 3'd3,
      ST_WAIT   = 3'd4,
      ST_SEND   = 3'd5
   } state_t;

   state_t                 state;
   logic [R*C*W_K-1:0]     k_reg;
   logic [C*W_X-1:0]       x_reg;
   logic [R*W_Y_OUT-1:0]   y_reg;
   logic [EW-1:0]          elem_cnt;
   logic [OW-1:0]          out_cnt;
   logic [GW-1:0]          gap_cnt;

   logic                   s_fire;
   logic                   m_fire;

   // Transfers happen when both sides of a handshake agree
   assign s_fire = s_valid & s_ready;
   assign m_fire = m_valid & m_ready;

   // The core sees the holding registers directly, so partial loads show up
   assign mvm_k = k_reg;
   assign mvm_x = x_reg;

   // Sequencer FSM with all control outputs registered alongside the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         k_reg     <= '0;
         x_reg     <= '0;
         y_reg     <= '0;
         elem_cnt  <= '0;
         out_cnt   <= '0;
         gap_cnt   <= '0;
         s_ready   <= 1'b0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         mvm_start <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         // err and mvm_start are single-cycle pulses
         err       <= 1'b0;
         mvm_start <= 1'b0;

         case (state)
            ST_IDLE: begin
               s_ready <= 1'b1;
               busy    <= 1'b0;
               if (s_fire) begin
                  case (s_data)
                     CMD_K: begin
                        state    <= ST_LOAD_K;
                        elem_cnt <= '0;
                        gap_cnt  <= '0;
                        busy     <= 1'b1;
                     end
                     CMD_X: begin
                        state    <= ST_LOAD_X;
                        elem_cnt <= '0;
                        gap_cnt  <= '0;
                        busy     <= 1'b1;
                     end
                     default: begin
                        err <= 1'b1;
                     end
                  endcase
               end
            end

            ST_LOAD_K: begin
               if (s_fire) begin
                  k_reg[elem_cnt*W_K +: W_K] <= s_data[W_K-1:0];
                  gap_cnt <= '0;
                  if (elem_cnt == K_LAST) begin
                     state    <= ST_IDLE;
                     elem_cnt <= '0;
                     busy     <= 1'b0;
                  end else begin
                     elem_cnt <= elem_cnt + EW'(1);
                  end
               end else if (gap_cnt == GAP_LAST) begin
                  // Sender went quiet mid-load: abandon, keep what arrived
                  err      <= 1'b1;
                  state    <= ST_IDLE;
                  elem_cnt <= '0;
                  gap_cnt  <= '0;
                  busy     <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end

            ST_LOAD_X: begin
               if (s_fire) begin
                  x_reg[elem_cnt*W_X +: W_X] <= s_data[W_X-1:0];
                  gap_cnt <= '0;
                  if (elem_cnt == X_LAST) begin
                     // Launch lands on the cycle right after the last X byte
                     state     <= ST_START;
                     elem_cnt  <= '0;
                     mvm_start <= 1'b1;
                     s_ready   <= 1'b0;
                  end else begin
                     elem_cnt <= elem_cnt + EW'(1);
                  end
               end else if (gap_cnt == GAP_LAST) begin
                  err      <= 1'b1;
                  state    <= ST_IDLE;
                  elem_cnt <= '0;
                  gap_cnt  <= '0;
                  busy     <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end

            ST_START: begin
               state <= ST_WAIT;
            end

            ST_WAIT: begin
               if (mvm_done) begin
                  // Element 0 goes out straight from the core's bus so the
                  // first TX byte is valid the cycle after done
                  y_reg   <= mvm_y;
                  out_cnt <= '0;
                  m_valid <= 1'b1;
                  m_data  <= mvm_y[W_Y_OUT-1:0];
                  state   <= ST_SEND;
               end
            end

            ST_SEND: begin
               if (m_fire) begin
                  if (out_cnt == OUT_LAST) begin
                     m_valid <= 1'b0;
                     out_cnt <= '0;
                     busy    <= 1'b0;
                     s_ready <= 1'b1;
                     state   <= ST_IDLE;
                  end else begin
                     out_cnt <= out_cnt + OW'(1);
                     m_data  <= y_reg[(int'(out_cnt) + 1)*W_Y_OUT +: W_Y_OUT];
                  end
               end
            end

            default: begin
               state   <= ST_IDLE;
               s_ready <= 1'b0;
               m_valid <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
